// File: rtl/vram_bus_arbiter.sv
// VRAM arbiter between the 68010 and the raster video fetch engine; video has priority, bounded by a run counter.
// Optional bus-error timeout on stalled CPU cycles is enabled with BUS_TIMEOUT_EN.
module vram_bus_arbiter #(
  parameter int unsigned ACC_CYC     = 2,
  parameter int unsigned MAX_VID_RUN = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic MCKR,
  input  logic SYSRES,
  input  logic AS_b,
  input  logic UDS_b,
  input  logic LDS_b,
  input  logic R_b_Vs_W,
  input  logic VRAM_b,
  input  logic WAIT_b,
  input  logic DTACK_EXT_b,
  input  logic VID_REQ,
  output logic VID_GNT,
  output logic CPU_SEL,
  output logic VRAM_OE_b,
  output logic VRAM_WE_H_b,
  output logic VRAM_WE_L_b,
  output logic DTACKn,
  output logic BERRn
);

  localparam int unsigned SW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam int unsigned RW = (MAX_VID_RUN > 1) ? $clog2(MAX_VID_RUN + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_VID,
    S_CPU,
    S_ACK
  } state_t;

  state_t        state, state_nx;
  logic [SW-1:0] slot_cnt, slot_nx;
  logic [RW-1:0] run_cnt, run_nx;
  logic          cpu_req, cpu_ok, berr_hold, slot_last;
  logic          gnt_nx, sel_nx, oe_nx, weh_nx, wel_nx, dtack_nx;

  assign cpu_req   = ~AS_b & ~VRAM_b & (~UDS_b | ~LDS_b);
  assign cpu_ok    = cpu_req & ~berr_hold;
  assign slot_last = (slot_cnt == SW'(ACC_CYC - 1));

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_cnt;
  logic          berr_set;

  assign berr_set  = ~AS_b & BERRn & DTACKn & DTACK_EXT_b & (to_cnt == TW'(TIMEOUT - 1));
  assign berr_hold = ~BERRn | berr_set;

  always_ff @(posedge MCKR or posedge SYSRES) begin
    if (SYSRES) begin
      to_cnt <= '0;
      BERRn  <= 1'b1;
    end else if (AS_b) begin
      to_cnt <= '0;
      BERRn  <= 1'b1;
    end else begin
      if (DTACKn && DTACK_EXT_b && (to_cnt != TW'(TIMEOUT)))
        to_cnt <= to_cnt + TW'(1);
      if (berr_set)
        BERRn <= 1'b0;
    end
  end
`else
  logic unused_ext;

  assign berr_hold  = 1'b0;
  assign unused_ext = DTACK_EXT_b;

  always_ff @(posedge MCKR or posedge SYSRES) begin
    if (SYSRES) BERRn <= 1'b1;
    else        BERRn <= 1'b1;
  end
`endif

  always_comb begin
    state_nx = state;
    slot_nx  = slot_cnt;
    run_nx   = run_cnt;
    unique case (state)
      S_IDLE: begin
        slot_nx = '0;
        if (VID_REQ && (!cpu_ok || (run_cnt < RW'(MAX_VID_RUN))))
          state_nx = S_VID;
        else if (cpu_ok)
          state_nx = S_CPU;
      end
      S_VID: begin
        if (slot_last) begin
          state_nx = S_IDLE;
          slot_nx  = '0;
        end else begin
          slot_nx = slot_cnt + SW'(1);
        end
      end
      S_CPU: begin
        if (AS_b) begin
          state_nx = S_IDLE;
          slot_nx  = '0;
        end else if (WAIT_b) begin
          if (slot_last) begin
            state_nx = S_ACK;
            slot_nx  = '0;
          end else begin
            slot_nx = slot_cnt + SW'(1);
          end
        end
      end
      S_ACK: begin
        if (AS_b)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // A timeout pulls a stalled CPU slot back to idle before strobes are re-registered.
    if (berr_hold && (state_nx == S_CPU || state_nx == S_ACK)) begin
      state_nx = S_IDLE;
      slot_nx  = '0;
    end

    if (!cpu_req)
      run_nx = '0;
    else if (state == S_IDLE && state_nx == S_CPU)
      run_nx = '0;
    else if (state == S_VID && slot_last && (run_cnt < RW'(MAX_VID_RUN)))
      run_nx = run_cnt + RW'(1);
  end

  always_comb begin
    gnt_nx   = (state_nx == S_VID);
    sel_nx   = (state_nx == S_CPU) || (state_nx == S_ACK);
    oe_nx    = ~(sel_nx & R_b_Vs_W);
    weh_nx   = 1'b1;
    wel_nx   = 1'b1;
    dtack_nx = ~(state_nx == S_ACK);
    if (state_nx == S_CPU && !R_b_Vs_W) begin
      weh_nx = UDS_b;
      wel_nx = LDS_b;
    end
  end

  always_ff @(posedge MCKR or posedge SYSRES) begin
    if (SYSRES) begin
      state       <= S_IDLE;
      slot_cnt    <= '0;
      run_cnt     <= '0;
      VID_GNT     <= 1'b0;
      CPU_SEL     <= 1'b0;
      VRAM_OE_b   <= 1'b1;
      VRAM_WE_H_b <= 1'b1;
      VRAM_WE_L_b <= 1'b1;
      DTACKn      <= 1'b1;
    end else begin
      state       <= state_nx;
      slot_cnt    <= slot_nx;
      run_cnt     <= run_nx;
      VID_GNT     <= gnt_nx;
      CPU_SEL     <= sel_nx;
      VRAM_OE_b   <= oe_nx;
      VRAM_WE_H_b <= weh_nx;
      VRAM_WE_L_b <= wel_nx;
      DTACKn      <= dtack_nx;
    end
  end

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Bench for vram_bus_arbiter: transaction-level model checked every cycle, plus directed
// latency/contention/wait/timeout cases with hand-derived cycle numbers.
module tb_vram_bus_arbiter;
  localparam int ACC  = 2;
  localparam int MAXR = 4;
  localparam int TMO  = 64;

  logic MCKR = 1'b0, SYSRES = 1'b1;
  logic AS_b = 1'b1, UDS_b = 1'b1, LDS_b = 1'b1, R_b_Vs_W = 1'b1, VRAM_b = 1'b1;
  logic WAIT_b = 1'b1, DTACK_EXT_b = 1'b1, VID_REQ = 1'b0;
  logic VID_GNT, CPU_SEL, VRAM_OE_b, VRAM_WE_H_b, VRAM_WE_L_b, DTACKn, BERRn;

  int checks = 0;
  int errors = 0;

  always #5 MCKR = ~MCKR;

  vram_bus_arbiter #(.ACC_CYC(ACC), .MAX_VID_RUN(MAXR), .TIMEOUT(TMO)) dut (
    .MCKR(MCKR), .SYSRES(SYSRES), .AS_b(AS_b), .UDS_b(UDS_b), .LDS_b(LDS_b),
    .R_b_Vs_W(R_b_Vs_W), .VRAM_b(VRAM_b), .WAIT_b(WAIT_b), .DTACK_EXT_b(DTACK_EXT_b),
    .VID_REQ(VID_REQ), .VID_GNT(VID_GNT), .CPU_SEL(CPU_SEL), .VRAM_OE_b(VRAM_OE_b),
    .VRAM_WE_H_b(VRAM_WE_H_b), .VRAM_WE_L_b(VRAM_WE_L_b), .DTACKn(DTACKn), .BERRn(BERRn)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a slot is either video (cycles left), or a CPU transfer (counted cycles left, then acked).
  int       vid_left, need, runs, to;
  bit       cpu_on, acked, berr;
  logic [6:0] e_out;   // {gnt, sel, oe_b, we_h_b, we_l_b, dtack_n, berr_n}

  task automatic model_step();
    bit req, reqm, fire, in_vid, in_cpu, in_ack;
    req  = !AS_b && !VRAM_b && (!UDS_b || !LDS_b);
    fire = 1'b0;
`ifdef BUS_TIMEOUT_EN
    fire = !AS_b && !berr && e_out[1] && DTACK_EXT_b && (to == TMO - 1);
`endif
    reqm   = req && !berr && !fire;
    in_vid = vid_left > 0;
    in_cpu = cpu_on && !acked;
    in_ack = cpu_on && acked;
    if (in_vid) begin
      vid_left--;
      if (vid_left == 0 && req && runs < MAXR) runs++;
    end else if (in_cpu) begin
      if (AS_b) cpu_on = 1'b0;
      else if (WAIT_b) begin
        need--;
        if (need == 0) acked = 1'b1;
      end
    end else if (in_ack) begin
      if (AS_b) cpu_on = 1'b0;
    end else if (VID_REQ && (!reqm || runs < MAXR)) begin
      vid_left = ACC;
    end else if (reqm) begin
      cpu_on = 1'b1; acked = 1'b0; need = ACC; runs = 0;
    end
    if (!req) runs = 0;
`ifdef BUS_TIMEOUT_EN
    if (AS_b) begin
      to = 0; berr = 1'b0;
    end else begin
      if (e_out[1] && DTACK_EXT_b && to < TMO) to++;
      if (fire) begin berr = 1'b1; cpu_on = 1'b0; end
    end
`endif
    e_out = {vid_left > 0, cpu_on, !(cpu_on && R_b_Vs_W),
             (cpu_on && !acked && !R_b_Vs_W) ? UDS_b : 1'b1,
             (cpu_on && !acked && !R_b_Vs_W) ? LDS_b : 1'b1,
             !(cpu_on && acked), !berr};
  endtask

  always @(posedge MCKR or posedge SYSRES) begin
    if (SYSRES) begin
      vid_left = 0; need = 0; runs = 0; to = 0;
      cpu_on = 1'b0; acked = 1'b0; berr = 1'b0;
      e_out = 7'b0011111;
    end else begin
      model_step();
    end
  end

  always @(negedge MCKR)
    if (!SYSRES)
      chk("outputs", {25'd0, VID_GNT, CPU_SEL, VRAM_OE_b, VRAM_WE_H_b, VRAM_WE_L_b, DTACKn, BERRn},
          {25'd0, e_out});

  task automatic nxt(); @(posedge MCKR); #1; endtask
  task automatic smp(); @(negedge MCKR); endtask

  logic [127:0] oe_tr, weh_tr, wel_tr, sel_tr, berr_tr;
  int res_dt, res_sel, res_gnt, res_berr;
  logic post_dt1, post_dt2;

  task automatic cpu_access(input bit rd, input bit u, input bit l, input bit vid,
                            input int wait_len, input int budget);
    bit prev_g;
    res_dt = -1; res_sel = -1; res_gnt = 0; res_berr = -1; prev_g = 1'b0;
    oe_tr = '1; weh_tr = '1; wel_tr = '1; sel_tr = '0; berr_tr = '1;
    nxt();
    AS_b = 1'b0; VRAM_b = 1'b0; UDS_b = u; LDS_b = l; R_b_Vs_W = rd; WAIT_b = 1'b1; VID_REQ = vid;
    for (int c = 1; c <= budget; c++) begin
      nxt();
      WAIT_b = (c <= wait_len) ? 1'b0 : 1'b1;
      smp();
      oe_tr[c] = VRAM_OE_b; weh_tr[c] = VRAM_WE_H_b; wel_tr[c] = VRAM_WE_L_b;
      sel_tr[c] = CPU_SEL; berr_tr[c] = BERRn;
      if (VID_GNT && !prev_g) res_gnt++;
      prev_g = VID_GNT;
      if (CPU_SEL && res_sel < 0) res_sel = c;
      if (!DTACKn) begin res_dt = c; break; end
      if (!BERRn) begin res_berr = c; break; end
    end
    nxt();
    AS_b = 1'b1; UDS_b = 1'b1; LDS_b = 1'b1; VRAM_b = 1'b1; WAIT_b = 1'b1; VID_REQ = 1'b0;
    smp(); post_dt1 = DTACKn;
    nxt(); smp(); post_dt2 = DTACKn;
  endtask

  bit gnt_seen = 1'b0;
  task automatic rnd_nxt();
    nxt();
    if (VID_REQ && gnt_seen) begin VID_REQ = 1'b0; gnt_seen = 1'b0; end
    else if (!VID_REQ && $urandom_range(0, 2) == 0) begin VID_REQ = 1'b1; gnt_seen = 1'b0; end
  endtask
  task automatic rnd_smp(); smp(); if (VID_GNT) gnt_seen = 1'b1; endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    #12;
    chk("reset_state", {25'd0, VID_GNT, CPU_SEL, VRAM_OE_b, VRAM_WE_H_b, VRAM_WE_L_b, DTACKn, BERRn},
        {25'd0, 7'b0011111});
    #9 SYSRES = 1'b0;

    // Uncontended read: OE from cycle 1, DTACKn at cycle 3, released a cycle after AS_b rises.
    cpu_access(1'b1, 1'b0, 1'b0, 1'b0, 0, 20);
    chk("rd_dtack_cycle", res_dt, 3);
    chk("rd_oe_c1_c3", {oe_tr[1], oe_tr[2], oe_tr[3]}, 3'b000);
    chk("rd_dtack_hold", post_dt1, 1'b0);
    chk("rd_dtack_release", post_dt2, 1'b1);

    // Upper-byte write.
    cpu_access(1'b0, 1'b0, 1'b1, 1'b0, 0, 20);
    chk("wr_dtack_cycle", res_dt, 3);
    chk("wr_we_h_trace", {weh_tr[1], weh_tr[2], weh_tr[3]}, 3'b001);
    chk("wr_we_l_trace", {wel_tr[1], wel_tr[2], wel_tr[3]}, 3'b111);

    // Contention: four video slots with idle gaps, then CPU at cycle 13, DTACKn at 15.
    cpu_access(1'b1, 1'b0, 1'b0, 1'b1, 0, 40);
    chk("cont_vid_slots", res_gnt, MAXR);
    chk("cont_cpu_sel_cycle", res_sel, 13);
    chk("cont_dtack_cycle", res_dt, 15);

    // Five wait cycles push DTACKn from 3 to 8.
    cpu_access(1'b1, 1'b0, 1'b0, 1'b0, 5, 30);
    chk("wait_dtack_cycle", res_dt, 8);

    // Stuck WAIT_b.
    cpu_access(1'b1, 1'b0, 1'b0, 1'b0, 80, 100);
`ifdef BUS_TIMEOUT_EN
    chk("tmo_berr_cycle", res_berr, TMO);
    chk("tmo_no_dtack", res_dt, -1);
    chk("tmo_berr_c63", berr_tr[TMO-1], 1'b1);
    chk("tmo_released", {sel_tr[TMO], oe_tr[TMO]}, 2'b01);
`else
    chk("notmo_dtack_cycle", res_dt, 83);
    chk("notmo_berr_high", &berr_tr[83:1], 1'b1);
`endif

    // Randomized traffic against the model.
    for (int t = 0; t < 300; t++) begin
      int gap, kind, hold;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin rnd_nxt(); rnd_smp(); end
      kind = $urandom_range(0, 9);
      hold = $urandom_range(1, 6);
      rnd_nxt();
      AS_b = 1'b0;
      VRAM_b = (kind == 0);
      R_b_Vs_W = $urandom_range(0, 1);
      {UDS_b, LDS_b} = (kind == 1) ? 2'b11 : 2'($urandom_range(0, 2));
      DTACK_EXT_b = (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int c = 0; c < 40; c++) begin
        rnd_smp();
        if (!DTACKn || !BERRn) break;
        if ((kind <= 1) && c >= hold) break;
        if ($urandom_range(0, 29) == 0) break;
        rnd_nxt();
        WAIT_b = ($urandom_range(0, 3) != 0);
      end
      rnd_nxt();
      AS_b = 1'b1; UDS_b = 1'b1; LDS_b = 1'b1; VRAM_b = 1'b1; WAIT_b = 1'b1; DTACK_EXT_b = 1'b1;
      rnd_smp();
    end
    nxt(); VID_REQ = 1'b0;
    repeat (4) nxt();

    // Asynchronous reset in the middle of a CPU slot.
    AS_b = 1'b0; VRAM_b = 1'b0; UDS_b = 1'b0; LDS_b = 1'b0; R_b_Vs_W = 1'b1;
    nxt(); nxt(); smp();
    chk("pre_reset_cpu_sel", CPU_SEL, 1'b1);
    @(posedge MCKR); #3 SYSRES = 1'b1;
    #1 chk("async_reset", {25'd0, VID_GNT, CPU_SEL, VRAM_OE_b, VRAM_WE_H_b, VRAM_WE_L_b, DTACKn, BERRn},
           {25'd0, 7'b0011111});
    AS_b = 1'b1; VRAM_b = 1'b1; UDS_b = 1'b1; LDS_b = 1'b1;
    smp(); #1 SYSRES = 1'b0;
    repeat (3) nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vram_bus_arbiter.md
Name: vram_bus_arbiter

Overview:
- Shares the video RAM between the 68010 video microprocessor and the raster video fetch engine.
- Decodes CPU bus cycles aimed at VRAM and generates VRAM strobes, the address-mux select and DTACKn back to the CPU.
- Video fetch has priority; a run counter stops the CPU from starving.
- Sits between the CPU pin-level wrapper (AS_b/UDS_b/LDS_b/R_b_Vs_W, VRAM_b decode) and the VRAM chips.

Parameters:
- ACC_CYC, 2: VRAM access length in MCKR cycles per slot (>=1).
- MAX_VID_RUN, 4: consecutive video slots granted while a CPU request is pending before the CPU is forced in (>=1).
- TIMEOUT, 64: cycles from AS_b fall to bus error (BUS_TIMEOUT_EN only).

Ports:
- MCKR  in  1  system clock, shared with the CPU.
- SYSRES  in  1  reset, asynchronous, active-high.
- AS_b  in  1  CPU address strobe, active-low.
- UDS_b  in  1  CPU upper data strobe, active-low.
- LDS_b  in  1  CPU lower data strobe, active-low.
- R_b_Vs_W  in  1  1=read, 0=write.
- VRAM_b  in  1  address decode, VRAM selected, active-low.
- WAIT_b  in  1  wait-state extend, active-low.
- DTACK_EXT_b  in  1  DTACK from other decoders (timeout use only).
- VID_REQ  in  1  video fetch request, level, held until granted.
- VID_GNT  out  1  high for the whole video slot.
- CPU_SEL  out  1  VRAM address/data mux selects the CPU.
- VRAM_OE_b  out  1  VRAM output enable, active-low.
- VRAM_WE_H_b  out  1  VRAM upper-byte write enable, active-low.
- VRAM_WE_L_b  out  1  VRAM lower-byte write enable, active-low.
- DTACKn  out  1  data acknowledge to the CPU, active-low.
- BERRn  out  1  bus error to the CPU, active-low.

Behaviour:
- All inputs are synchronous to MCKR. All outputs are registered.
- cpu_req = ~AS_b & ~VRAM_b & (~UDS_b | ~LDS_b).
- Reset (async, any state): state=IDLE; run_cnt=0; slot counter=0.
  - VID_GNT=0, CPU_SEL=0.
  - VRAM_OE_b, VRAM_WE_H_b, VRAM_WE_L_b, DTACKn, BERRn all =1.
- States: IDLE, VID, CPU, ACK.
- IDLE: grant selection, in order:
  - VID_REQ & (!cpu_req | run_cnt<MAX_VID_RUN) -> VID.
  - else cpu_req -> CPU.
  - else stay.
- VID: VID_GNT=1 for exactly ACC_CYC cycles, then IDLE.
  - run_cnt increments at slot end if cpu_req is high.
  - run_cnt clears whenever cpu_req is low or the CPU is granted.
  - run_cnt saturates at MAX_VID_RUN.
- CPU: CPU_SEL=1 for the slot.
  - Read: VRAM_OE_b=0.
  - Write: VRAM_WE_H_b=UDS_b and VRAM_WE_L_b=LDS_b.
  - The slot counter advances only while WAIT_b=1. After ACC_CYC counted cycles -> ACK.
- ACK: DTACKn=0 and CPU_SEL=1.
  - Write enables return to 1 on entry to ACK; data is held.
  - VRAM_OE_b stays 0 for reads until exit.
  - Exit to IDLE the cycle after AS_b is sampled high. DTACKn returns to 1 in that same cycle.
- Aborted cycle (AS_b high while in CPU): -> IDLE next cycle, strobes off, DTACKn never asserted.
- Non-VRAM cycles (VRAM_b=1): the block never drives DTACKn low; the video request is served normally.
- No back-to-back CPU grant without passing through IDLE. One idle cycle is guaranteed between slots.
- Latency, uncontended read with ACC_CYC=2: AS_b low at cycle 0 -> CPU at cycle 1 -> DTACKn low at cycle 3.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With the macro:
  - A counter clears while AS_b=1.
  - It counts while AS_b=0 and DTACKn=1 and DTACK_EXT_b=1.
  - At TIMEOUT: BERRn=0 until AS_b is sampled high. The FSM goes to IDLE, strobes are released, and DTACKn stays 1.
  - This bounds stuck WAIT_b and unmapped accesses.
- Without the macro: BERRn is held at 1, the counter is absent, and WAIT_b may extend indefinitely.

Test Plan:
- Reset: assert SYSRES mid-CPU slot -> same-cycle async VID_GNT=0, CPU_SEL=0, all strobes=1, DTACKn=1, BERRn=1.
- CPU read, ACC_CYC=2, VID_REQ=0: AS_b/VRAM_b/UDS_b/LDS_b low at cycle 0 -> VRAM_OE_b=0 cycles 1-3, DTACKn=0 from cycle 3 until one cycle after AS_b rises.
- Byte write: UDS_b=0, LDS_b=1, R_b_Vs_W=0 -> VRAM_WE_H_b=0 cycles 1-2, VRAM_WE_L_b=1 throughout, DTACKn=0 at cycle 3.
- Contention: VID_REQ held high, CPU requests -> exactly 4 VID slots (ACC_CYC each plus idle cycles), then the CPU slot, run_cnt=0 after grant.
- WAIT_b=0 for 5 cycles during a CPU slot -> DTACKn assertion delayed by exactly 5 cycles (cycle 8).
- BUS_TIMEOUT_EN defined, TIMEOUT=64, WAIT_b stuck low -> BERRn=0 at cycle 64 after AS_b fall, DTACKn=1, strobes released. Undefined -> BERRn stays 1.
